// File: rtl/md_sched_pkg.sv
// Shared defines for the HI/LO multiply/divide scheduler: state encodings,
// op codes, default multiplier latency, stall levels and op-class helpers.
package md_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int unsigned MUL_LAT_DEF = 2;

  localparam logic STALL_ON  = 1'b1;
  localparam logic STALL_OFF = 1'b0;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// 3-bit load/decrement counter with zero flag; times the multiplier wait.
module md_lat_cnt (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [2:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign o_zero = (r_cnt == 3'd0);

endmodule

// File: rtl/md_sched.sv
// HI/LO scheduler: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO and stalls the pipe.
// Optional macro MD_DIV0_BYPASS_EN: divide-by-zero completes without the divider.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  md_state_e   r_state, w_next;
  logic        r_mul_signed, r_div_signed, r_div_annul;
  logic [31:0] r_mul_ina, r_mul_inb, r_div_opa, r_div_opb, r_hi, r_lo;

  logic        w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic        w_latch_mul, w_latch_div, w_clr_ops;
  logic        w_hi_we, w_lo_we;
  logic [31:0] w_hi_d, w_lo_d;

  md_lat_cnt u_lat_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_clr      (flush),
    .i_load     (w_cnt_load),
    .i_load_val (3'(MUL_LAT - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_latch_mul = 1'b0;
    w_latch_div = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_d      = src_a;
    w_lo_d      = src_a;
    stallreq    = STALL_OFF;
    unique case (r_state)
      ST_IDLE: begin
        if (op_valid && (is_mul(op_code) || is_div(op_code))) stallreq = STALL_ON;
        if (op_valid && !flush) begin
          if (is_mul(op_code)) begin
            w_next      = ST_MUL_WAIT;
            w_cnt_load  = 1'b1;
            w_latch_mul = 1'b1;
          end else if (is_div(op_code)) begin
`ifdef MD_DIV0_BYPASS_EN
            if (src_b == '0) begin
              w_next  = ST_DONE;
              w_hi_we = 1'b1;
              w_lo_we = 1'b1;
              w_lo_d  = 32'hFFFF_FFFF;
            end else begin
              w_next      = ST_DIV_RUN;
              w_latch_div = 1'b1;
            end
`else
            w_next      = ST_DIV_RUN;
            w_latch_div = 1'b1;
`endif
          end else if (op_code == OP_MTHI) begin
            w_hi_we = 1'b1;
          end else if (op_code == OP_MTLO) begin
            w_lo_we = 1'b1;
          end
        end
      end
      ST_MUL_WAIT: begin
        stallreq = STALL_ON;
        if (flush) begin
          w_next = ST_IDLE;
        end else if (w_cnt_zero) begin
          w_next  = ST_DONE;
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = mul_result[63:32];
          w_lo_d  = mul_result[31:0];
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_DIV_RUN: begin
        stallreq = STALL_ON;
        if (flush) begin
          w_next = ST_IDLE;
        end else if (div_ready) begin
          w_next  = ST_DONE;
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = div_result[63:32];
          w_lo_d  = div_result[31:0];
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operands drop back to zero whenever the FSM returns to IDLE.
  assign w_clr_ops = (r_state != ST_IDLE) && (w_next == ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_mul_signed <= 1'b0;
      r_mul_ina    <= '0;
      r_mul_inb    <= '0;
      r_div_signed <= 1'b0;
      r_div_opa    <= '0;
      r_div_opb    <= '0;
      r_div_annul  <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_state     <= w_next;
      r_div_annul <= flush && (r_state == ST_DIV_RUN);
      if (w_latch_mul) begin
        r_mul_signed <= (op_code == OP_MULT);
        r_mul_ina    <= src_a;
        r_mul_inb    <= src_b;
      end else if (w_clr_ops) begin
        r_mul_signed <= 1'b0;
        r_mul_ina    <= '0;
        r_mul_inb    <= '0;
      end
      if (w_latch_div) begin
        r_div_signed <= (op_code == OP_DIV);
        r_div_opa    <= src_a;
        r_div_opb    <= src_b;
      end else if (w_clr_ops) begin
        r_div_signed <= 1'b0;
        r_div_opa    <= '0;
        r_div_opb    <= '0;
      end
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

  assign mul_signed = r_mul_signed;
  assign mul_ina    = r_mul_ina;
  assign mul_inb    = r_mul_inb;
  assign div_signed = r_div_signed;
  assign div_opa    = r_div_opa;
  assign div_opb    = r_div_opb;
  assign div_annul  = r_div_annul;
  assign div_start  = (r_state == ST_DIV_RUN);
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MUL_LAT, default 2: multiplier latency in cycles from operand presentation to valid mul_result, range 1..7.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 flush  in  1  abort any in-flight operation.
REQ-005 op_valid  in  1  the EX-stage instruction is a HI/LO operation.
REQ-006 op_code  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are no-ops.
REQ-007 src_a, src_b  in  32 each  rs and rt operands.
REQ-008 stallreq  out  1  pipeline stall request to the stall controller.
REQ-009 mul_signed  out  1; mul_ina, mul_inb  out  32 each  multiplier controls and operands; mul_result  in  64.
REQ-010 div_start, div_signed, div_annul  out  1 each; div_opa, div_opb  out  32 each  divider controls and operands; div_ready  in  1; div_result  in  64 ({remainder, quotient}).
REQ-011 hi_o, lo_o  out  32 each  architectural HI and LO registers.
REQ-012 busy  out  1  state is not IDLE.

Function
REQ-013 FSM states: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE->MUL_WAIT on op_valid with MULT/MULTU.
- IDLE->DIV_RUN on op_valid with DIV/DIVU.
REQ-014 Operands and signedness shall be latched on FSM entry and held on mul_*/div_* until the next IDLE.
REQ-015 MUL_WAIT shall count MUL_LAT cycles, then capture mul_result into {hi,lo} and go to DONE.
REQ-016 div_start shall be high every cycle in DIV_RUN until div_ready=1; on div_ready, hi<=div_result[63:32], lo<=div_result[31:0], and the FSM goes to DONE.
REQ-017 DONE->IDLE unconditionally; no new operation is accepted in DONE, so the still-present op_valid is not restarted.
REQ-018 stallreq = (IDLE & op_valid & op is MUL/DIV) | MUL_WAIT | DIV_RUN; stallreq is low in DONE so the pipeline advances exactly once.
REQ-019 MTHI/MTLO in IDLE shall write src_a to hi or lo at the next edge, with no stall and no state change.
REQ-020 Total MULT latency shall be MUL_LAT+1 stalled cycles; DIV latency shall be the divider latency plus 1.
REQ-021 flush in any state shall go to IDLE next edge, pulse div_annul for one cycle if in DIV_RUN, and leave hi/lo unwritten.
- flush takes priority over a simultaneous div_ready or count expiry.
REQ-022 flush with op_valid in IDLE shall start nothing and write nothing.
REQ-023 div_ready arriving outside DIV_RUN shall be ignored.

Reset
REQ-024 On resetn=0, the block shall immediately present: state IDLE, hi_o=lo_o=0, all mul_*/div_* outputs 0, stallreq=0, busy=0, counter 0.
REQ-025 Reset mid-operation discards the operation; div_annul is not required during reset.

Configuration
REQ-026 Macro MD_DIV0_BYPASS_EN, when defined: DIV/DIVU with src_b==0 shall skip the divider and go IDLE->DONE, writing hi<=src_a, lo<=32'hFFFFFFFF, with one stalled cycle.
- When undefined, divide-by-zero is issued to the divider like any other divide.

Structure
REQ-027 State encodings, op_code values and the default MUL_LAT shall live in the shared defines package next to the stall constants.
REQ-028 One sub-module, md_lat_cnt (3-bit load/decrement counter with a zero flag), shall implement the MUL_WAIT count.

Verification
REQ-029 MULT with a=32'hFFFFFFFE, b=3, MUL_LAT=2 -> stallreq high 3 cycles; hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-030 DIVU with a=100, b=7, divider model ready after 33 cycles -> div_start held until ready; lo=14, hi=2; stallreq drops in DONE.
REQ-031 MTHI with src_a=32'h1234 -> hi=32'h1234 next cycle, stallreq never asserted.
REQ-032 flush on the 5th cycle of DIV_RUN -> div_annul pulses 1 cycle, IDLE next, hi/lo unchanged.
REQ-033 DIV a=5, b=0 with MD_DIV0_BYPASS_EN -> hi=5, lo=32'hFFFFFFFF after 1 stalled cycle; without the macro -> div_start asserted.
REQ-034 resetn asserted during MUL_WAIT -> outputs 0 without a clock edge; a subsequent MULTU 2x3 gives lo=6.
